vram_blit_engine: RTL and testbench
===================================

// Module: vram_blit_engine
// PURPOSE
//  Hardware fill/scroll engine for the 80x30 text-mode VRAM (7.2 layout: 40 words/row, 2 glyphs/word).
//  Sits upstream of the text VGA interface: a NIOS-visible Avalon-MM slave that owns a write port
//  into the shared dual-port VRAM and performs whole-screen clear or one-row scroll-up.
//  Optionally aligns each operation to the VGA vertical sync.
// PARAMETERS
//  WORDS_PER_ROW  40    VRAM words per text row
//  ROWS           30    text rows; total words = WORDS_PER_ROW*ROWS (1200)
//  ADDR_W         11    VRAM word-address width
//  RD_LAT         1     RAM read latency in cycles (RAM_RDATA valid RD_LAT cycles after RAM_RDEN)
// PORTS
//  CLK            in   1       50 MHz system clock (shared with VGA interface)
//  RESET          in   1       synchronous, active-high reset
//  AVL_CS         in   1       Avalon-MM chip select
//  AVL_READ       in   1       Avalon-MM read
//  AVL_WRITE      in   1       Avalon-MM write
//  AVL_ADDR       in   2       register index
//  AVL_WRITEDATA  in   32      write data
//  AVL_READDATA   out  32      read data, registered
//  vs             in   1       VGA vertical sync from vga_controller, active low
//  RAM_ADDR       out  ADDR_W  VRAM word address
//  RAM_WDATA      out  32      VRAM write data
//  RAM_WREN       out  1       VRAM write enable, all 4 bytes
//  RAM_RDEN       out  1       VRAM read enable
//  RAM_RDATA      in   32      VRAM read data
//  BUSY           out  1       operation in progress
//  IRQ            out  1       level interrupt = DONE sticky bit
// BEHAVIOUR
//  Registers (write on AVL_CS&AVL_WRITE; read returns data 1 cycle after AVL_CS&AVL_READ):
//   0 CMD     W: [0] FILL, [1] SCROLL, [2] WAIT_VSYNC.  R: {29'b0, WAIT_VSYNC_last, DONE, BUSY}
//   1 FILL    R/W 32-bit fill word
//   2 STATUS  R: {30'b0, DONE, BUSY}; W: bit1=1 clears DONE (and IRQ)
//   3 COUNT   R: number of completed operations, 16-bit, zero-extended, wraps at 0xFFFF
//  Reset: all outputs 0, FILL=0, DONE=0, COUNT=0, FSM=IDLE. Reset mid-operation aborts with no further RAM write.
//  CMD accepted only in IDLE; CMD writes while BUSY are ignored (no queue). FILL+SCROLL both set -> SCROLL.
//  CMD with neither FILL nor SCROLL set -> no-op. On accept: shadow FILL word latched, BUSY=1 next cycle.
//  FILL writes to the FILL register during BUSY do not affect the running operation.
//  FSM: IDLE -> (WAIT_VSYNC ? WAIT_VS : op) ; WAIT_VS -> op on vs falling edge (vs_q & ~vs).
//   FILL_ST: one write/cycle, addr 0..1199 ascending; 1200 cycles.
//   SCR_RD: RAM_RDEN=1, RAM_ADDR=dst+WORDS_PER_ROW; SCR_WAIT: RD_LAT cycles;
//   SCR_WR: RAM_WREN=1, RAM_ADDR=dst, RAM_WDATA=captured RAM_RDATA; dst++; loop for dst 0..1159.
//   SCR_CLR: last row (1160..1199) written with shadow FILL, one/cycle.
//   DONE_ST: BUSY=0, DONE=1, COUNT++, -> IDLE (1 cycle).
//  Cycle budget: fill 1200 + 2; scroll 1160*(RD_LAT+2) + 40 + 2.
//  RAM_WREN and RAM_RDEN never asserted in the same cycle; RAM_ADDR never exceeds 1199.
//  All RAM_* outputs are registered; RAM_WREN/RAM_RDEN low in IDLE, WAIT_VS, DONE_ST.
//  DONE set and CPU clear in same cycle -> DONE stays 1 (set wins).
//  Address counter is ADDR_W bits; terminal-count compare, never wraps past total words.
// TESTING
//  FILL=0x0F200F20, CMD=0x1 -> exactly 1200 writes, addr 0..1199, data 0x0F200F20; BUSY 1202 cycles; DONE, IRQ=1.
//  Preload word[i]=i, FILL=0, CMD=0x2 -> word[i]=i+40 for i<1160, word[1160..1199]=0; COUNT=1.
//  CMD=0x5 with vs held high 500 cycles -> no RAM activity until vs falls; first write the cycle after the edge.
//  CMD=0x1 then CMD=0x2 while BUSY -> second ignored; COUNT=1 at end, no read cycles seen.
//  RESET asserted at write #600 of fill -> next cycle RAM_WREN=0, BUSY=0, DONE=0, FSM idle; new CMD works.
//  STATUS write 0x2 -> DONE/IRQ clear; CMD=0x3 -> scroll performed; CMD=0x0 -> no-op; COUNT wraps 0xFFFF->0.

Source files
------------

// File: rtl/vram_blit_engine.sv
// Avalon-MM fill/scroll engine for the 80x30 text-mode VRAM.
// Owns the VRAM write port and clears the screen or scrolls it up one row, optionally on vsync.
module vram_blit_engine #(
    parameter int WORDS_PER_ROW = 40,
    parameter int ROWS          = 30,
    parameter int ADDR_W        = 11,
    parameter int RD_LAT        = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              AVL_CS,
    input  logic              AVL_READ,
    input  logic              AVL_WRITE,
    input  logic [1:0]        AVL_ADDR,
    input  logic [31:0]       AVL_WRITEDATA,
    output logic [31:0]       AVL_READDATA,
    input  logic              vs,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [31:0]       RAM_WDATA,
    output logic              RAM_WREN,
    output logic              RAM_RDEN,
    input  logic [31:0]       RAM_RDATA,
    output logic              BUSY,
    output logic              IRQ
);

    localparam int TOTAL = WORDS_PER_ROW * ROWS;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
    localparam logic [ADDR_W-1:0] LAST_DST  = ADDR_W'(TOTAL - WORDS_PER_ROW - 1);
    localparam logic [ADDR_W-1:0] ROW_OFS   = ADDR_W'(WORDS_PER_ROW);
    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_VS, FILL_ST, SCR_RD, SCR_WAIT, SCR_WR, SCR_CLR, DONE_ST
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_cnt, addr_cnt_n;
    logic [LAT_W-1:0]  lat_cnt, lat_cnt_n;
    logic [ADDR_W-1:0] ram_addr_n;
    logic [31:0]       ram_wdata_n;
    logic              ram_wren_n, ram_rden_n;
    logic              done_set;

    logic [31:0] fill_reg, shadow_fill;
    logic        op_scroll, wait_vs_last, done, busy, vs_q;
    logic [15:0] count;

    logic reg_wr, cmd_wr, cmd_go, vs_fall;

    assign reg_wr  = AVL_CS & AVL_WRITE;
    assign cmd_wr  = reg_wr && (AVL_ADDR == 2'd0);
    assign cmd_go  = cmd_wr && (state == IDLE) && (AVL_WRITEDATA[0] | AVL_WRITEDATA[1]);
    assign vs_fall = vs_q & ~vs;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            addr_cnt  <= '0;
            lat_cnt   <= '0;
            RAM_ADDR  <= '0;
            RAM_WDATA <= '0;
            RAM_WREN  <= 1'b0;
            RAM_RDEN  <= 1'b0;
        end else begin
            state     <= state_n;
            addr_cnt  <= addr_cnt_n;
            lat_cnt   <= lat_cnt_n;
            RAM_ADDR  <= ram_addr_n;
            RAM_WDATA <= ram_wdata_n;
            RAM_WREN  <= ram_wren_n;
            RAM_RDEN  <= ram_rden_n;
        end
    end

    // RAM strobes are decoded from the current state and registered, so each
    // state's bus cycle appears on the RAM port one clock later.
    always_comb begin
        state_n     = state;
        addr_cnt_n  = addr_cnt;
        lat_cnt_n   = lat_cnt;
        ram_addr_n  = '0;
        ram_wdata_n = '0;
        ram_wren_n  = 1'b0;
        ram_rden_n  = 1'b0;
        done_set    = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_go) begin
                    addr_cnt_n = '0;
                    lat_cnt_n  = '0;
                    if (AVL_WRITEDATA[2])      state_n = WAIT_VS;
                    else if (AVL_WRITEDATA[1]) state_n = SCR_RD;
                    else                       state_n = FILL_ST;
                end
            end
            WAIT_VS: begin
                if (vs_fall) state_n = op_scroll ? SCR_RD : FILL_ST;
            end
            FILL_ST, SCR_CLR: begin
                ram_wren_n  = 1'b1;
                ram_addr_n  = addr_cnt;
                ram_wdata_n = shadow_fill;
                if (addr_cnt == LAST_ADDR) state_n = DONE_ST;
                else                       addr_cnt_n = addr_cnt + 1'b1;
            end
            SCR_RD: begin
                ram_rden_n = 1'b1;
                ram_addr_n = addr_cnt + ROW_OFS;
                lat_cnt_n  = '0;
                state_n    = SCR_WAIT;
            end
            SCR_WAIT: begin
                if (lat_cnt == LAT_LAST) state_n = SCR_WR;
                else                     lat_cnt_n = lat_cnt + 1'b1;
            end
            SCR_WR: begin
                ram_wren_n  = 1'b1;
                ram_addr_n  = addr_cnt;
                ram_wdata_n = RAM_RDATA;
                addr_cnt_n  = addr_cnt + 1'b1;
                state_n     = (addr_cnt == LAST_DST) ? SCR_CLR : SCR_RD;
            end
            DONE_ST: begin
                done_set = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Register file; a DONE set in the same cycle as a CPU clear takes priority.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fill_reg     <= '0;
            shadow_fill  <= '0;
            op_scroll    <= 1'b0;
            wait_vs_last <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
            count        <= '0;
            vs_q         <= 1'b0;
            AVL_READDATA <= '0;
        end else begin
            vs_q <= vs;
            if (reg_wr && (AVL_ADDR == 2'd1)) fill_reg <= AVL_WRITEDATA;
            if (cmd_wr && (state == IDLE)) wait_vs_last <= AVL_WRITEDATA[2];
            if (cmd_go) begin
                shadow_fill <= fill_reg;
                op_scroll   <= AVL_WRITEDATA[1];
                busy        <= 1'b1;
            end else if (state == DONE_ST) begin
                busy <= 1'b0;
            end
            if (done_set) begin
                done  <= 1'b1;
                count <= count + 16'd1;
            end else if (reg_wr && (AVL_ADDR == 2'd2) && AVL_WRITEDATA[1]) begin
                done <= 1'b0;
            end
            if (AVL_CS && AVL_READ) begin
                case (AVL_ADDR)
                    2'd0:    AVL_READDATA <= {29'b0, wait_vs_last, done, busy};
                    2'd1:    AVL_READDATA <= fill_reg;
                    2'd2:    AVL_READDATA <= {30'b0, done, busy};
                    default: AVL_READDATA <= {16'b0, count};
                endcase
            end
        end
    end

    assign BUSY = busy;
    assign IRQ  = done;

endmodule

// File: tb/tb_vram_blit_engine.sv
// Self-checking bench for vram_blit_engine: behavioural VRAM model plus a write scoreboard
// filled when each command is issued and drained as the engine writes.
module tb_vram_blit_engine;

    localparam int TOTAL      = 1200;
    localparam int WPR        = 40;
    localparam int FILL_CYC   = TOTAL + 2;
    localparam int SCROLL_CYC = (TOTAL - WPR) * 3 + WPR + 2;

    logic        clk = 1'b0;
    logic        RESET;
    logic        AVL_CS, AVL_READ, AVL_WRITE;
    logic [1:0]  AVL_ADDR;
    logic [31:0] AVL_WRITEDATA, AVL_READDATA;
    logic        vs;
    logic [10:0] RAM_ADDR;
    logic [31:0] RAM_WDATA, RAM_RDATA;
    logic        RAM_WREN, RAM_RDEN, BUSY, IRQ;

    typedef struct packed {
        logic [10:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] mem [0:TOTAL-1];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          wr_total = 0;
    int          rd_total = 0;
    int          exp_count = 0;

    always #10 clk = ~clk;

    vram_blit_engine dut (
        .CLK(clk), .RESET(RESET),
        .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
        .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
        .vs(vs),
        .RAM_ADDR(RAM_ADDR), .RAM_WDATA(RAM_WDATA), .RAM_WREN(RAM_WREN),
        .RAM_RDEN(RAM_RDEN), .RAM_RDATA(RAM_RDATA),
        .BUSY(BUSY), .IRQ(IRQ)
    );

    // One-cycle-latency VRAM model
    initial begin
        RAM_RDATA = '0;
        forever begin
            @(posedge clk);
            if (RAM_WREN && RAM_ADDR < 11'd1200) mem[RAM_ADDR] <= RAM_WDATA;
            if (RAM_RDEN && RAM_ADDR < 11'd1200) RAM_RDATA <= mem[RAM_ADDR];
        end
    end

    // Bus monitor and scoreboard drain
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (RAM_WREN || RAM_RDEN) begin
                n_checks++;
                if ((RAM_WREN && RAM_RDEN) || RAM_ADDR > 11'd1199)
                    $display("[TB] FAIL ram_bus: wren=%0b rden=%0b addr=%0d, required one strobe and addr<=1199",
                             RAM_WREN, RAM_RDEN, RAM_ADDR);
                else n_pass++;
            end
            if (RAM_RDEN) rd_total++;
            if (RAM_WREN) begin
                wr_total++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("[TB] FAIL ram_write: unexpected write addr=%0d data=%h, required no write",
                             RAM_ADDR, RAM_WDATA);
                end else begin
                    e = exp_q.pop_front();
                    if ({RAM_ADDR, RAM_WDATA} !== {e.addr, e.data})
                        $display("[TB] FAIL ram_write: addr=%0d data=%h, required addr=%0d data=%h",
                                 RAM_ADDR, RAM_WDATA, e.addr, e.data);
                    else n_pass++;
                end
            end
        end
    end

    task automatic avl_write(input logic [1:0] a, input logic [31:0] d);
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = a; AVL_WRITEDATA = d;
        @(posedge clk); #1;
        AVL_CS = 1'b0; AVL_WRITE = 1'b0;
    endtask

    task automatic avl_read(input logic [1:0] a, output logic [31:0] d);
        AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = a;
        @(posedge clk); #1;
        AVL_CS = 1'b0; AVL_READ = 1'b0;
        d = AVL_READDATA;
    endtask

    task automatic push_fill(input logic [31:0] d);
        for (int i = 0; i < TOTAL; i++) exp_q.push_back({11'(i), d});
    endtask

    task automatic push_scroll(input logic [31:0] d);
        for (int i = 0; i < TOTAL - WPR; i++) exp_q.push_back({11'(i), mem[i + WPR]});
        for (int i = TOTAL - WPR; i < TOTAL; i++) exp_q.push_back({11'(i), d});
    endtask

    // Called right after the accepting edge; counts edges including that one until BUSY drops
    task automatic wait_op(input int budget, output int cyc);
        cyc = 1;
        while (BUSY === 1'b1 && cyc < budget + 10) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic check_status(input string name, input logic [1:0] a, input logic [31:0] req);
        logic [31:0] got;
        avl_read(a, got);
        n_checks++;
        if (got !== req) $display("[TB] FAIL %s: got %h, required %h", name, got, req);
        else n_pass++;
    endtask

    task automatic test_reset();
        RESET = 1'b1; AVL_CS = 0; AVL_READ = 0; AVL_WRITE = 0; AVL_ADDR = 0; AVL_WRITEDATA = 0; vs = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({RAM_WREN, RAM_RDEN, BUSY, IRQ, RAM_ADDR, RAM_WDATA, AVL_READDATA} !== '0)
            $display("[TB] FAIL reset_outputs: wren=%0b rden=%0b busy=%0b irq=%0b addr=%0d wdata=%h rdata=%h, required all 0",
                     RAM_WREN, RAM_RDEN, BUSY, IRQ, RAM_ADDR, RAM_WDATA, AVL_READDATA);
        else n_pass++;
        RESET = 1'b0;
        @(posedge clk); #1;
        check_status("reset_fill", 2'd1, 32'h0);
        check_status("reset_status", 2'd2, 32'h0);
        check_status("reset_count", 2'd3, 32'h0);
    endtask

    task automatic test_fill();
        int cyc, wr0;
        avl_write(2'd1, 32'h0F200F20);
        push_fill(32'h0F200F20);
        wr0 = wr_total;
        avl_write(2'd0, 32'h1);
        wait_op(FILL_CYC, cyc);
        exp_count++;
        n_checks++;
        if (cyc != FILL_CYC || BUSY !== 1'b0) $display("[TB] FAIL fill_cycles: got %0d busy=%0b, required %0d busy=0", cyc, BUSY, FILL_CYC);
        else n_pass++;
        n_checks++;
        if (wr_total - wr0 != TOTAL || exp_q.size() != 0)
            $display("[TB] FAIL fill_writes: got %0d left %0d, required %0d left 0", wr_total - wr0, exp_q.size(), TOTAL);
        else n_pass++;
        n_checks++;
        if (IRQ !== 1'b1) $display("[TB] FAIL fill_irq: got %0b, required 1", IRQ);
        else n_pass++;
        check_status("fill_status", 2'd2, 32'h2);
        check_status("fill_count", 2'd3, 32'(exp_count));
    endtask

    task automatic test_scroll();
        int cyc, rd0;
        for (int i = 0; i < TOTAL; i++) mem[i] <= 32'(i);
        avl_write(2'd1, 32'h0);
        push_scroll(32'h0);
        rd0 = rd_total;
        avl_write(2'd0, 32'h2);
        wait_op(SCROLL_CYC, cyc);
        exp_count++;
        n_checks++;
        if (cyc != SCROLL_CYC || BUSY !== 1'b0) $display("[TB] FAIL scroll_cycles: got %0d busy=%0b, required %0d busy=0", cyc, BUSY, SCROLL_CYC);
        else n_pass++;
        n_checks++;
        if (rd_total - rd0 != TOTAL - WPR || exp_q.size() != 0)
            $display("[TB] FAIL scroll_reads: got %0d left %0d, required %0d left 0", rd_total - rd0, exp_q.size(), TOTAL - WPR);
        else n_pass++;
        n_checks++;
        if (mem[0] !== 32'd40 || mem[1159] !== 32'd1199 || mem[1160] !== 32'd0 || mem[1199] !== 32'd0)
            $display("[TB] FAIL scroll_mem: got %0d %0d %0d %0d, required 40 1199 0 0", mem[0], mem[1159], mem[1160], mem[1199]);
        else n_pass++;
        check_status("scroll_count", 2'd3, 32'(exp_count));
    endtask

    task automatic test_vsync_wait();
        int cyc, wr0, rd0;
        avl_write(2'd1, 32'h12345678);
        push_fill(32'h12345678);
        wr0 = wr_total; rd0 = rd_total;
        avl_write(2'd0, 32'h5);
        repeat (500) begin @(posedge clk); #1; end
        n_checks++;
        if (wr_total != wr0 || rd_total != rd0 || BUSY !== 1'b1)
            $display("[TB] FAIL vsync_hold: got %0d accesses busy=%0b, required 0 accesses busy=1",
                     (wr_total - wr0) + (rd_total - rd0), BUSY);
        else n_pass++;
        vs = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (RAM_WREN !== 1'b0) $display("[TB] FAIL vsync_edge: got wren=%0b, required 0", RAM_WREN);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (RAM_WREN !== 1'b1 || RAM_ADDR !== 11'd0)
            $display("[TB] FAIL vsync_first_write: got wren=%0b addr=%0d, required wren=1 addr=0", RAM_WREN, RAM_ADDR);
        else n_pass++;
        wait_op(FILL_CYC, cyc);
        vs = 1'b1;
        exp_count++;
        n_checks++;
        if (BUSY !== 1'b0 || exp_q.size() != 0 || wr_total - wr0 != TOTAL)
            $display("[TB] FAIL vsync_fill: got busy=%0b writes=%0d left=%0d, required busy=0 writes=%0d left=0",
                     BUSY, wr_total - wr0, exp_q.size(), TOTAL);
        else n_pass++;
        check_status("vsync_cmd_readback", 2'd0, 32'h6);
    endtask

    task automatic test_back_to_back();
        int cyc, wr0, rd0;
        avl_write(2'd2, 32'h2);
        avl_write(2'd1, 32'hA5A5_0F0F);
        push_fill(32'hA5A5_0F0F);
        wr0 = wr_total; rd0 = rd_total;
        avl_write(2'd0, 32'h1);
        repeat (5) begin @(posedge clk); #1; end
        avl_write(2'd1, 32'hDEADBEEF);
        avl_write(2'd0, 32'h2);
        check_status("busy_cmd_readback", 2'd0, 32'h1);
        wait_op(FILL_CYC, cyc);
        repeat (10) begin @(posedge clk); #1; end
        exp_count++;
        n_checks++;
        if (BUSY !== 1'b0 || rd_total != rd0 || wr_total - wr0 != TOTAL || exp_q.size() != 0)
            $display("[TB] FAIL busy_ignore: got busy=%0b reads=%0d writes=%0d left=%0d, required 0 0 %0d 0",
                     BUSY, rd_total - rd0, wr_total - wr0, exp_q.size(), TOTAL);
        else n_pass++;
        check_status("busy_ignore_count", 2'd3, 32'(exp_count));
        check_status("fill_reg_readback", 2'd1, 32'hDEADBEEF);
    endtask

    task automatic test_done_set_wins();
        avl_write(2'd2, 32'h2);
        push_fill(32'hDEADBEEF);
        avl_write(2'd0, 32'h1);
        repeat (TOTAL) begin @(posedge clk); #1; end
        avl_write(2'd2, 32'h2);
        exp_count++;
        check_status("done_set_wins", 2'd2, 32'h2);
    endtask

    task automatic test_reset_mid_op();
        int cyc, wr0, k;
        avl_write(2'd1, 32'h0BAD0BAD);
        push_fill(32'h0BAD0BAD);
        wr0 = wr_total;
        avl_write(2'd0, 32'h1);
        k = 0;
        while (!(RAM_WREN === 1'b1 && RAM_ADDR === 11'd599) && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        n_checks++;
        if (k >= 2000) $display("[TB] FAIL reset_find_write600: got timeout, required write to addr 599");
        else n_pass++;
        RESET = 1'b1;
        @(posedge clk); #1;
        RESET = 1'b0;
        n_checks++;
        if (RAM_WREN !== 1'b0 || BUSY !== 1'b0 || IRQ !== 1'b0)
            $display("[TB] FAIL reset_abort: got wren=%0b busy=%0b irq=%0b, required 0 0 0", RAM_WREN, BUSY, IRQ);
        else n_pass++;
        repeat (3) begin @(posedge clk); #1; end
        n_checks++;
        if (wr_total - wr0 != 600 || exp_q.size() != TOTAL - 600)
            $display("[TB] FAIL reset_write_count: got %0d left %0d, required 600 left %0d", wr_total - wr0, exp_q.size(), TOTAL - 600);
        else n_pass++;
        exp_q.delete();
        exp_count = 0;
        check_status("reset_mid_count", 2'd3, 32'h0);
        push_fill(32'h0);
        avl_write(2'd0, 32'h1);
        wait_op(FILL_CYC, cyc);
        exp_count++;
        n_checks++;
        if (cyc != FILL_CYC || exp_q.size() != 0)
            $display("[TB] FAIL post_reset_fill: got %0d left %0d, required %0d left 0", cyc, exp_q.size(), FILL_CYC);
        else n_pass++;
        check_status("post_reset_count", 2'd3, 32'(exp_count));
    endtask

    task automatic test_status_noop_dual();
        int cyc, wr0, rd0;
        avl_write(2'd2, 32'h2);
        n_checks++;
        if (IRQ !== 1'b0) $display("[TB] FAIL irq_clear: got %0b, required 0", IRQ);
        else n_pass++;
        check_status("status_clear", 2'd2, 32'h0);
        wr0 = wr_total; rd0 = rd_total;
        avl_write(2'd0, 32'h0);
        repeat (4) begin @(posedge clk); #1; end
        n_checks++;
        if (BUSY !== 1'b0 || wr_total != wr0 || rd_total != rd0)
            $display("[TB] FAIL noop_cmd: got busy=%0b accesses=%0d, required busy=0 accesses=0",
                     BUSY, (wr_total - wr0) + (rd_total - rd0));
        else n_pass++;
        check_status("noop_count", 2'd3, 32'(exp_count));
        for (int i = 0; i < TOTAL; i++) mem[i] <= 32'(i * 3 + 7);
        avl_write(2'd1, 32'h55AA55AA);
        push_scroll(32'h55AA55AA);
        rd0 = rd_total;
        avl_write(2'd0, 32'h3);
        wait_op(SCROLL_CYC, cyc);
        exp_count++;
        n_checks++;
        if (cyc != SCROLL_CYC || rd_total - rd0 != TOTAL - WPR || exp_q.size() != 0)
            $display("[TB] FAIL dual_cmd_scroll: got cyc=%0d reads=%0d left=%0d, required %0d %0d 0",
                     cyc, rd_total - rd0, exp_q.size(), SCROLL_CYC, TOTAL - WPR);
        else n_pass++;
        check_status("dual_cmd_count", 2'd3, 32'(exp_count));
    endtask

    initial begin
        test_reset();
        test_fill();
        test_scroll();
        test_vsync_wait();
        test_back_to_back();
        test_done_set_wins();
        test_reset_mid_op();
        test_status_noop_dual();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
